craft_encrypt_core: RTL

CRAFT_ENCRYPT_CORE -- requirements
Module: craft_encrypt_core

---
 rtl/craft_pkg.sv | 20 ++
 rtl/craft_round.sv | 31 +++
 rtl/craft_round_constants.sv | 21 ++
 rtl/craft_encrypt_core.sv | 91 +++++++++
 4 files changed

// File: rtl/craft_pkg.sv
// Shared CRAFT types and tables: nibble-vector type (I0 at index 0), S-box,
// nibble permutation P and tweak permutation Q.
package craft_pkg;
  localparam int NUM_ROUNDS_DEF = 32;

  typedef logic [3:0]        nib_t;
  typedef nib_t [0:15]       nvec_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  // Entry i of each table sits in nibble slot i.
  localparam nvec_t SBOX = 64'hcad3ebf789150246;
  localparam nvec_t P    = 64'hfcdea98b65471230;
  localparam nvec_t Q    = 64'hcaf5e892b374601d;

  function automatic nvec_t permute(input nvec_t x, input nvec_t tab);
    nvec_t y;
    for (int i = 0; i < 16; i++) y[i] = x[tab[i]];
    return y;
  endfunction
endpackage

// File: rtl/craft_round.sv
// One combinational CRAFT round; the final round stops after AddTweakey.
module craft_round
  import craft_pkg::*;
(
  input  logic [63:0] state,
  input  logic [7:0]  rc,
  input  logic [63:0] tk,
  input  logic        last,
  output logic [63:0] nxt
);
  nvec_t s, mc, at, pn, sb;
  logic  unused;

  assign s      = state;
  assign unused = rc[3];

  always_comb begin
    mc = s;
    for (int j = 0; j < 4; j++) begin
      mc[j]   = s[j] ^ s[j+8] ^ s[j+12];
      mc[j+4] = s[j+4] ^ s[j+12];
    end
    at    = mc;
    at[4] = mc[4] ^ rc[7:4];
    at[5] = mc[5] ^ {1'b0, rc[2:0]};
    at    = at ^ nvec_t'(tk);
    pn    = permute(at, P);
    for (int i = 0; i < 16; i++) sb[i] = SBOX[pn[i]];
    nxt = last ? at : sb;
  end
endmodule

// File: rtl/craft_round_constants.sv
// Round-constant generator: 4-bit and 3-bit LFSRs, held at RC_0 while rc_rst.
module craft_round_constants (
  input  logic       clk,
  input  logic       rc_rst,
  output logic [7:0] rc
);
  logic [3:0] a;
  logic [2:0] b;

  always_ff @(posedge clk) begin
    if (rc_rst) begin
      a <= 4'h1;
      b <= 3'h1;
    end else begin
      a <= {a[0] ^ a[1], a[3:1]};
      b <= {b[0] ^ b[1], b[2:1]};
    end
  end

  assign rc = {a, 1'b0, b};
endmodule

// File: rtl/craft_encrypt_core.sv
// Iterative CRAFT encryption: one round per clock, external round-constant source.
module craft_encrypt_core
  import craft_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  pt,
  input  logic [127:0] key,
  input  logic [63:0]  tweak,
  input  logic [7:0]   rc,
  output logic         rc_rst,
  output logic         busy,
  output logic         done,
  output logic [63:0]  ct
);
  localparam int RW = (NUM_ROUNDS > 4) ? $clog2(NUM_ROUNDS) : 2;

  fsm_t             state, nstate;
  logic [RW-1:0]    r;
  logic [63:0]      st, rnd;
  logic [3:0][63:0] tk;
  logic [63:0]      qt;
  logic             last;

  assign last = (r == RW'(NUM_ROUNDS - 1));
  assign qt   = permute(tweak, Q);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    busy   = 1'b1;
    rc_rst = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) nstate = S_RUN;
      end
      S_RUN: begin
        rc_rst = 1'b0;
        if (last) nstate = S_DONE;
      end
      S_DONE:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  craft_round u_round (
    .state (st),
    .rc    (rc),
    .tk    (tk[r[1:0]]),
    .last  (last),
    .nxt   (rnd)
  );

  // The counter parks at the last round through DONE; only a new accept clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st   <= '0;
      tk   <= '0;
      r    <= '0;
      ct   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (start) begin
          st <= pt;
          tk <= {key[63:0] ^ qt, key[127:64] ^ qt, key[63:0] ^ tweak, key[127:64] ^ tweak};
          r  <= '0;
        end
        S_RUN: begin
          st <= rnd;
          if (last) begin
            ct   <= rnd;
            done <= 1'b1;
          end else begin
            r <= r + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
